matrix_scan_controller: RTL and testbench

Row-scan controller for the 8x8 LED matrix. It owns a double-buffered 8x8 frame store with a valid/ready row-write port for the host logic, and time-multiplexes the displayed buffer onto the `d` column bus and the one-hot `row` strobes with a blanking guard between rows. Buffer swaps are requested by the host and happen only at a frame boundary, so the display never tears. It sits between pattern-generating logic and the matrix/segment pins in the top level.

---
 rtl/matrix_led_pkg.sv | 20 ++
 rtl/matrix_row_timer.sv | 45 ++++
 rtl/matrix_scan_controller.sv | 122 ++++++++++++
 tb/tb_matrix_scan_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_led_pkg.sv
// Shared types for the 8x8 LED matrix row-scan controller.
// Row pattern/index types and the buffer-swap FSM encoding.
package matrix_led_pkg;

   localparam int MATRIX_ROWS = 8;
   localparam int MATRIX_COLS = 8;

   typedef logic [7:0] matrix_row_t;
   typedef logic [2:0] matrix_row_idx_t;

   typedef enum logic {
      SWAP_IDLE,
      SWAP_PENDING
   } swap_state_t;

   function automatic matrix_row_t row_strobe(input matrix_row_idx_t idx);
      return matrix_row_t'(1) << idx;
   endfunction

endpackage

// File: rtl/matrix_row_timer.sv
// Row-slot timer: counts each slot, opens the on-window and steps the
// row index mid-guard so the strobe change is hidden by blanking.
module matrix_row_timer
   import matrix_led_pkg::*;
#(
   parameter int ROW_PERIOD = 27000,
   parameter int GUARD      = 540
) (
   input  logic            i_clock,
   input  logic            i_reset,
   output logic            o_row_en,
   output logic            o_advance,
   output matrix_row_idx_t o_row_idx
);

   localparam int CW = (ROW_PERIOD > 1) ? $clog2(ROW_PERIOD) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ROW_PERIOD - 1);
   localparam logic [CW-1:0] CNT_ON   = CW'(ROW_PERIOD - GUARD);
   localparam logic [CW-1:0] CNT_ADV  = CW'(ROW_PERIOD - GUARD / 2);

   logic [CW-1:0]   r_cnt;
   matrix_row_idx_t r_row_idx;
   logic            w_wrap;
   logic            w_advance;

   assign w_wrap    = (r_cnt == CNT_LAST);
   assign w_advance = (r_cnt == CNT_ADV);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_cnt     <= '0;
         r_row_idx <= '0;
      end else begin
         r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
         if (w_advance) begin
            r_row_idx <= r_row_idx + 1'b1;
         end
      end
   end

   assign o_row_en  = (r_cnt < CNT_ON);
   assign o_advance = w_advance;
   assign o_row_idx = r_row_idx;

endmodule

// File: rtl/matrix_scan_controller.sv
// 8x8 LED matrix row-scan controller with tear-free frame swaps.
// MATRIX_SCAN_DOUBLE_BUFFER_EN selects double buffering; else single buffer.
module matrix_scan_controller
   import matrix_led_pkg::*;
#(
   parameter int ROW_PERIOD = 27000,
   parameter int GUARD      = 540
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [2:0]  wr_row,
   input  logic [7:0]  wr_data,
   input  logic        swap_req,
   output logic        swap_done,
   output logic        frame_start,
   output logic [7:0]  d,
   output logic [7:0]  row
);

   logic            w_row_en;
   logic            w_advance;
   matrix_row_idx_t w_row_idx;
   logic            w_boundary;
   logic            w_wr_fire;
   logic            w_swap_now;

   swap_state_t r_state;
   logic        r_swap_done;
   logic        r_frame_start;

   matrix_row_timer #(
      .ROW_PERIOD (ROW_PERIOD),
      .GUARD      (GUARD)
   ) u_timer (
      .i_clock   (clock),
      .i_reset   (reset),
      .o_row_en  (w_row_en),
      .o_advance (w_advance),
      .o_row_idx (w_row_idx)
   );

   assign w_boundary = w_advance && (w_row_idx == 3'd7);
   assign w_wr_fire  = wr_valid && wr_ready;
   assign w_swap_now = (r_state == SWAP_PENDING) && w_boundary;

   // A request landing on a boundary in IDLE waits for the next one.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= SWAP_IDLE;
         r_swap_done   <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_swap_done   <= w_swap_now;
         r_frame_start <= w_boundary;
         unique case (r_state)
            SWAP_IDLE: begin
               if (swap_req) begin
                  r_state <= SWAP_PENDING;
               end
            end
            SWAP_PENDING: begin
               if (w_boundary) begin
                  r_state <= SWAP_IDLE;
               end
            end
         endcase
      end
   end

`ifdef MATRIX_SCAN_DOUBLE_BUFFER_EN
   matrix_row_t r_buf_a [MATRIX_ROWS];
   matrix_row_t r_buf_b [MATRIX_ROWS];
   logic        r_front_sel;

   // r_front_sel low shows A; writes always land in the hidden buffer.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < MATRIX_ROWS; i++) begin
            r_buf_a[i] <= '0;
            r_buf_b[i] <= '0;
         end
         r_front_sel <= 1'b0;
      end else begin
         if (w_wr_fire) begin
            if (r_front_sel) begin
               r_buf_a[wr_row] <= wr_data;
            end else begin
               r_buf_b[wr_row] <= wr_data;
            end
         end
         if (w_swap_now) begin
            r_front_sel <= ~r_front_sel;
         end
      end
   end

   assign wr_ready = (r_state == SWAP_IDLE);
   assign d        = r_front_sel ? r_buf_b[w_row_idx] : r_buf_a[w_row_idx];
`else
   matrix_row_t r_buf [MATRIX_ROWS];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < MATRIX_ROWS; i++) begin
            r_buf[i] <= '0;
         end
      end else if (w_wr_fire) begin
         r_buf[wr_row] <= wr_data;
      end
   end

   assign wr_ready = 1'b1;
   assign d        = r_buf[w_row_idx];
`endif

   assign row         = w_row_en ? row_strobe(w_row_idx) : '0;
   assign swap_done   = r_swap_done;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Bench for matrix_scan_controller: directed scenarios plus random
// traffic checked every cycle against a time-based frame model.
module tb_matrix_scan_controller;

   localparam int RP    = 20;
   localparam int GD    = 4;
   localparam int FRAME = 8 * RP;
   localparam int BDY_T = 7 * RP + RP - GD / 2;

`ifdef MATRIX_SCAN_DOUBLE_BUFFER_EN
   localparam bit DBUF = 1'b1;
`else
   localparam bit DBUF = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       wr_valid = 1'b0;
   logic [2:0] wr_row = '0;
   logic [7:0] wr_data = '0;
   logic       swap_req = 1'b0;
   logic       wr_ready;
   logic       swap_done;
   logic       frame_start;
   logic [7:0] d;
   logic [7:0] row;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   matrix_scan_controller #(
      .ROW_PERIOD (RP),
      .GUARD      (GD)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_row      (wr_row),
      .wr_data     (wr_data),
      .swap_req    (swap_req),
      .swap_done   (swap_done),
      .frame_start (frame_start),
      .d           (d),
      .row         (row)
   );

   // Model: two frames, cycle count since reset, pending flag.
   logic [7:0] m_mem [2][8];
   int         m_t;
   int         m_fsel;
   bit         m_pend;
   bit         m_done;
   bit         m_fs;

   function automatic int m_idx();
      return ((m_t + GD / 2 - 1) / RP) % 8;
   endfunction

   function automatic logic [7:0] m_row();
      return ((m_t % RP) < (RP - GD)) ? 8'(1 << m_idx()) : 8'h00;
   endfunction

   function automatic int m_front();
      return DBUF ? m_fsel : 0;
   endfunction

   function automatic int m_back();
      return DBUF ? 1 - m_fsel : 0;
   endfunction

   function automatic logic [7:0] m_d();
      return m_mem[m_front()][m_idx()];
   endfunction

   function automatic bit m_ready();
      return DBUF ? !m_pend : 1'b1;
   endfunction

   task automatic m_reset();
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 8; r++)
            m_mem[b][r] = 8'h00;
      m_t    = 0;
      m_fsel = 0;
      m_pend = 1'b0;
      m_done = 1'b0;
      m_fs   = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)",
                  tag, got, exp, m_t);
      end
   endtask

   // One clock: check outputs mid-cycle, advance model, pass the edge.
   task automatic cyc();
      bit bdy;
      @(negedge clock);
      check("d", 32'(d), 32'(m_d()));
      check("row", 32'(row), 32'(m_row()));
      check("wr_ready", 32'(wr_ready), 32'(m_ready()));
      check("swap_done", 32'(swap_done), 32'(m_done));
      check("frame_start", 32'(frame_start), 32'(m_fs));
      if (reset) begin
         m_reset();
      end else begin
         bdy = ((m_t % FRAME) == BDY_T);
         if (wr_valid && m_ready())
            m_mem[m_back()][wr_row] = wr_data;
         m_fs   = bdy;
         m_done = bdy && m_pend;
         if (m_pend && bdy) begin
            m_pend = 1'b0;
            m_fsel = 1 - m_fsel;
         end else if (!m_pend && swap_req) begin
            m_pend = 1'b1;
         end
         m_t++;
      end
      @(posedge clock);
      #1;
   endtask

   logic [7:0] pat [8];

   initial begin
      pat[0] = 8'h81; pat[1] = 8'h42; pat[2] = 8'h24; pat[3] = 8'h18;
      pat[4] = 8'h18; pat[5] = 8'h24; pat[6] = 8'h42; pat[7] = 8'h81;

      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      m_reset();
      reset = 1'b0;

      repeat (25) cyc();

      for (int i = 0; i < 8; i++) begin
         wr_valid = 1'b1;
         wr_row   = 3'(i);
         wr_data  = pat[i];
         cyc();
      end
      wr_valid = 1'b0;
      swap_req = 1'b1;
      cyc();
      swap_req = 1'b0;
      repeat (2 * FRAME) cyc();

      swap_req = 1'b1;
      cyc();
      swap_req = 1'b0;
      wr_valid = 1'b1;
      wr_row   = 3'd3;
      wr_data  = 8'hFF;
      repeat (FRAME + 5) cyc();
      wr_valid = 1'b0;
      repeat (FRAME) cyc();

      wr_valid = 1'b1;
      wr_row   = 3'd2;
      wr_data  = 8'h3C;
      swap_req = 1'b1;
      cyc();
      wr_valid = 1'b0;
      swap_req = 1'b0;
      repeat (2 * FRAME) cyc();

      for (int k = 0; k < FRAME && (m_t % FRAME) != BDY_T; k++) cyc();
      swap_req = 1'b1;
      cyc();
      swap_req = 1'b0;
      repeat (2 * FRAME + 10) cyc();

      for (int k = 0; k < FRAME && m_idx() != 3; k++) cyc();
      swap_req = 1'b1;
      cyc();
      swap_req = 1'b0;
      for (int k = 0; k < FRAME && m_idx() != 5; k++) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      repeat (2 * FRAME) cyc();

      for (int k = 0; k < 3000; k++) begin
         wr_valid = 1'($urandom_range(0, 1));
         wr_row   = 3'($urandom);
         wr_data  = 8'($urandom);
         swap_req = ($urandom_range(0, 59) == 0);
         reset    = ($urandom_range(0, 999) == 0);
         cyc();
      end
      reset    = 1'b0;
      wr_valid = 1'b0;
      swap_req = 1'b0;
      repeat (2 * FRAME) cyc();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
